// File: rtl/pwr_mode_seq.sv
// Purpose  : low-power entry/exit sequencer between the IDLE decoder and the clock controller.
// Latency  : IDLE_ST rises 1 cycle after IDLE_req; RUN is reached 1+SETTLE_CYC cycles after the wake event.
// Backpressure: none; IDLE_req is a pulse, and requests arriving outside RUN are dropped without a nack.
//
// Ports:
//   DSPCLK, P_RSTn          core clock, async active-low reset
//   IDLE_req, IDLE_mode     IDLE instruction pulse and requested mode (00 idle, 01 standby, 10 sleep, 11 reserved)
//   IRQ_pend, IRQ_msk       pending interrupts and wake-enable mask
//   PWDACK, Awake           clock controller sleep ack and oscillator-settled indication
//   force_wake              ICE/debug wake pulse
//   tmr_val                 wake timer reload (only when PWR_WAKE_TMR_EN is defined)
//   IDLE_ST_h, IDLE_ST, IRE handshake into the clock controller
//   core_stall              pipeline hold, asserted from ENTER through the settle window
//   idle_nack, wake_done    1-cycle reject / return-to-RUN pulses
//   wake_src                0 irq, 1 awake, 2 force, 3 timer; held until the next wake
//
// Optional feature: define PWR_WAKE_TMR_EN to add the wake down-counter and the tmr_val port.

module pwr_mode_seq #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned TMR_W      = 12
) (
  input  logic             DSPCLK,
  input  logic             P_RSTn,
  input  logic             IDLE_req,
  input  logic [1:0]       IDLE_mode,
  input  logic [3:0]       IRQ_pend,
  input  logic [3:0]       IRQ_msk,
  input  logic             PWDACK,
  input  logic             Awake,
  input  logic             force_wake,
`ifdef PWR_WAKE_TMR_EN
  input  logic [TMR_W-1:0] tmr_val,
`endif
  output logic             IDLE_ST_h,
  output logic             IDLE_ST,
  output logic [3:0]       IRE,
  output logic             core_stall,
  output logic             idle_nack,
  output logic             wake_done,
  output logic [1:0]       wake_src
);

  typedef enum logic [2:0] {
    S_RUN, S_ENTER, S_WAIT_ACK, S_LOWPWR, S_EXIT, S_SETTLE
  } state_e;

  localparam logic [1:0] M_IDLE  = 2'b00;
  localparam logic [1:0] M_STBY  = 2'b01;
  localparam logic [1:0] M_SLEEP = 2'b10;
  localparam logic [1:0] M_RSVD  = 2'b11;

  localparam logic [1:0] WS_IRQ   = 2'd0;
  localparam logic [1:0] WS_AWAKE = 2'd1;
  localparam logic [1:0] WS_FORCE = 2'd2;
  localparam logic [1:0] WS_TMR   = 2'd3;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_e     state_q;
  logic [1:0] mode_q;
  logic [3:0] ire_q;
  logic       idle_st_h_q;
  logic       idle_st_q;
  logic       stall_q;
  logic       nack_q;
  logic       wdone_q;
  logic [1:0] wsrc_q;
  logic [3:0] settle_q;
  logic       awake_q;
  logic [TMR_W-1:0] tmr_q;

  logic irq_eff;
  logic awake_rise;
  logic is_sleep;
  logic tmr_hit;

  assign irq_eff    = |(IRQ_pend & IRQ_msk);
  assign awake_rise = Awake & ~awake_q;
  assign is_sleep   = (mode_q == M_SLEEP);
  // Counter value 1 means this LOWPWR cycle is the one that takes it to zero.
  // A zero count (tmr_val==0 or timer absent) never fires.
  assign tmr_hit    = !is_sleep && (tmr_q == TMR_W'(1));

`ifndef PWR_WAKE_TMR_EN
  // Timer absent: counter tied off so the wake priority logic is shared by both builds.
  assign tmr_q = '0;
`endif

  always_ff @(posedge DSPCLK or negedge P_RSTn) begin
    if (!P_RSTn) begin
      state_q     <= S_RUN;
      mode_q      <= M_IDLE;
      ire_q       <= '0;
      idle_st_h_q <= 1'b0;
      idle_st_q   <= 1'b0;
      stall_q     <= 1'b0;
      nack_q      <= 1'b0;
      wdone_q     <= 1'b0;
      wsrc_q      <= WS_IRQ;
      settle_q    <= '0;
      awake_q     <= 1'b0;
`ifdef PWR_WAKE_TMR_EN
      tmr_q       <= '0;
`endif
    end else begin
      // pulse outputs default low every cycle
      idle_st_h_q <= 1'b0;
      nack_q      <= 1'b0;
      wdone_q     <= 1'b0;
      awake_q     <= Awake;

      case (state_q)
        S_RUN: begin
          if (IDLE_req) begin
            if (irq_eff || IDLE_mode == M_RSVD) begin
              nack_q <= 1'b1;
            end else begin
              mode_q      <= IDLE_mode;
              ire_q       <= (IDLE_mode == M_SLEEP) ? 4'b1000 :
                             (IDLE_mode == M_STBY)  ? {1'b0, IRQ_msk[2:0]} : 4'b0000;
              state_q     <= S_ENTER;
              idle_st_h_q <= 1'b1;
              idle_st_q   <= 1'b1;
              stall_q     <= 1'b1;
            end
          end
        end

        S_ENTER: begin
`ifdef PWR_WAKE_TMR_EN
          tmr_q <= tmr_val;
`endif
          state_q <= is_sleep ? S_WAIT_ACK : S_LOWPWR;
        end

        S_WAIT_ACK: begin
          // interrupts cannot wake the core until the controller has acked
          if (force_wake) begin
            state_q   <= S_EXIT;
            idle_st_q <= 1'b0;
            ire_q     <= '0;
            wsrc_q    <= WS_FORCE;
          end else if (PWDACK) begin
            state_q <= S_LOWPWR;
          end
        end

        S_LOWPWR: begin
          if (force_wake || (is_sleep && awake_rise) || tmr_hit || (!is_sleep && irq_eff)) begin
            state_q   <= S_EXIT;
            idle_st_q <= 1'b0;
            ire_q     <= '0;
            wsrc_q    <= force_wake               ? WS_FORCE :
                         (is_sleep && awake_rise) ? WS_AWAKE :
                         tmr_hit                  ? WS_TMR   : WS_IRQ;
`ifdef PWR_WAKE_TMR_EN
            tmr_q     <= '0;
`endif
          end
`ifdef PWR_WAKE_TMR_EN
          // the count is frozen while the oscillator is down in sleep
          else if (!is_sleep && tmr_q != '0) begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
`endif
        end

        S_EXIT: begin
          state_q  <= S_SETTLE;
          settle_q <= SETTLE_LOAD;
        end

        S_SETTLE: begin
          if (settle_q == '0) begin
            state_q <= S_RUN;
            stall_q <= 1'b0;
            wdone_q <= 1'b1;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end

        default: state_q <= S_RUN;
      endcase
    end
  end

  assign IDLE_ST_h  = idle_st_h_q;
  assign IDLE_ST    = idle_st_q;
  assign IRE        = ire_q;
  assign core_stall = stall_q;
  assign idle_nack  = nack_q;
  assign wake_done  = wdone_q;
  assign wake_src   = wsrc_q;

endmodule

// File: tb/tb_pwr_mode_seq.sv
// Purpose  : self-checking bench for pwr_mode_seq; expectations are event times derived from the mode rules.
// Latency  : checks entry at +1 cycle and RUN return at wake+1+SETTLE.
// Backpressure: not applicable.

module tb_pwr_mode_seq;

  localparam int SETTLE = 4;
  localparam int TW     = 12;

  logic          DSPCLK = 1'b0;
  logic          P_RSTn;
  logic          IDLE_req;
  logic [1:0]    IDLE_mode;
  logic [3:0]    IRQ_pend;
  logic [3:0]    IRQ_msk;
  logic          PWDACK;
  logic          Awake;
  logic          force_wake;
  logic [TW-1:0] tmr_val;
  logic          IDLE_ST_h;
  logic          IDLE_ST;
  logic [3:0]    IRE;
  logic          core_stall;
  logic          idle_nack;
  logic          wake_done;
  logic [1:0]    wake_src;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] last_src;

  always #5 DSPCLK = ~DSPCLK;

  pwr_mode_seq #(.SETTLE_CYC(SETTLE), .TMR_W(TW)) dut (
    .DSPCLK     (DSPCLK),
    .P_RSTn     (P_RSTn),
    .IDLE_req   (IDLE_req),
    .IDLE_mode  (IDLE_mode),
    .IRQ_pend   (IRQ_pend),
    .IRQ_msk    (IRQ_msk),
    .PWDACK     (PWDACK),
    .Awake      (Awake),
    .force_wake (force_wake),
`ifdef PWR_WAKE_TMR_EN
    .tmr_val    (tmr_val),
`endif
    .IDLE_ST_h  (IDLE_ST_h),
    .IDLE_ST    (IDLE_ST),
    .IRE        (IRE),
    .core_stall (core_stall),
    .idle_nack  (idle_nack),
    .wake_done  (wake_done),
    .wake_src   (wake_src)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge DSPCLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_h"},     IDLE_ST_h,  0);
    check_eq({tag, "_st"},    IDLE_ST,    0);
    check_eq({tag, "_ire"},   IRE,        0);
    check_eq({tag, "_stall"}, core_stall, 0);
    check_eq({tag, "_nack"},  idle_nack,  0);
    check_eq({tag, "_done"},  wake_done,  0);
    check_eq({tag, "_src"},   wake_src,   0);
  endtask

  // One IDLE instruction from request to RUN.
  // nat: the mode's own wake (irq for idle/standby, Awake rise for sleep); frc: force_wake.
  // Sleep without nat is woken by force_wake while still waiting for PWDACK.
  // tmr != 0 with idle/standby and no nat/frc exercises the wake timer.
  task automatic run_op(input logic [1:0] mode, input logic [3:0] msk, input logic [3:0] pend,
                        input bit nat, input bit frc, input int gap, input int ackd,
                        input int rst_at, input int tmr);
    bit         reject;
    bit         early;
    bit         use_tmr;
    logic [3:0] exp_ire;
    logic [1:0] exp_src;

    reject  = ((pend & msk) != 0) || (mode == 2'b11);
    exp_ire = (mode == 2'b10) ? 4'b1000 : (mode == 2'b01) ? {1'b0, msk[2:0]} : 4'b0000;
    use_tmr = (tmr != 0) && (mode != 2'b10) && !nat && !frc;
    exp_src = frc ? 2'd2 : use_tmr ? 2'd3 : (mode == 2'b10) ? 2'd1 : 2'd0;
    early   = (mode != 2'b10) && nat && !frc && (gap == 0);

    check_eq("src_held", wake_src, last_src);
    check_eq("run_st", IDLE_ST, 0);
    check_eq("run_stall", core_stall, 0);

    IDLE_req  = 1'b1;
    IDLE_mode = mode;
    IRQ_msk   = msk;
    IRQ_pend  = pend;
    tmr_val   = TW'(tmr);
    tick();
    IDLE_req = 1'b0;
    IRQ_pend = 4'b0;

    if (reject) begin
      check_eq("rej_nack", idle_nack, 1);
      check_eq("rej_h", IDLE_ST_h, 0);
      check_eq("rej_st", IDLE_ST, 0);
      check_eq("rej_stall", core_stall, 0);
      tick();
      check_eq("rej_nack_pulse", idle_nack, 0);
      check_eq("rej_st2", IDLE_ST, 0);
      return;
    end

    check_eq("ent_h", IDLE_ST_h, 1);
    check_eq("ent_st", IDLE_ST, 1);
    check_eq("ent_stall", core_stall, 1);
    check_eq("ent_ire", IRE, exp_ire);
    check_eq("ent_nack", idle_nack, 0);

    // an interrupt raised during ENTER must be acted on only once LOWPWR is reached
    if (early) IRQ_pend = msk;
    tick();
    check_eq("ent_h_pulse", IDLE_ST_h, 0);
    check_eq("ent_st2", IDLE_ST, 1);

    if (early) begin
      tick();
    end else begin
      if (mode == 2'b10) begin
        for (int i = 0; i < ackd; i++) begin
          IRQ_pend = 4'($urandom);
          tick();
          check_eq("wack_st", IDLE_ST, 1);
          check_eq("wack_done", wake_done, 0);
        end
        IRQ_pend = 4'b0;
        if (!nat) begin
          force_wake = 1'b1;
        end else begin
          PWDACK = 1'b1;
          tick();
          PWDACK = 1'b0;
          check_eq("ack_st", IDLE_ST, 1);
        end
      end
      if (!(mode == 2'b10 && !nat)) begin
        if (use_tmr) begin
          for (int i = 0; i < tmr - 1; i++) begin
            tick();
            check_eq("tmr_st", IDLE_ST, 1);
          end
        end else begin
          for (int i = 0; i < gap; i++) begin
            IDLE_req = 1'($urandom);
            IRQ_pend = (mode == 2'b10) ? 4'($urandom) : (4'($urandom) & ~msk);
            tick();
            check_eq("lp_st", IDLE_ST, 1);
            check_eq("lp_stall", core_stall, 1);
            check_eq("lp_nack", idle_nack, 0);
            check_eq("lp_done", wake_done, 0);
          end
          IDLE_req = 1'b0;
          IRQ_pend = 4'b0;
          if (frc) force_wake = 1'b1;
          if (nat) begin
            if (mode == 2'b10) Awake = 1'b1;
            else IRQ_pend = msk;
          end
        end
      end
      tick();
    end

    // wake event was sampled on the edge just passed
    force_wake = 1'b0;
    Awake      = 1'b0;
    IRQ_pend   = 4'b0;
    check_eq("exit_st", IDLE_ST, 0);
    check_eq("exit_ire", IRE, 0);
    check_eq("exit_stall", core_stall, 1);
    check_eq("exit_done", wake_done, 0);

    for (int i = 1; i <= SETTLE + 1; i++) begin
      tick();
      if (i == rst_at) begin
        P_RSTn = 1'b0;
        #2;
        check_all_zero("rst");
        last_src = 2'd0;
        #2;
        P_RSTn = 1'b1;
        for (int j = 0; j < 2 * SETTLE; j++) begin
          tick();
          check_eq("rst_done", wake_done, 0);
          check_eq("rst_stall", core_stall, 0);
        end
        return;
      end
      if (i <= SETTLE) begin
        check_eq("settle_done", wake_done, 0);
        check_eq("settle_stall", core_stall, 1);
      end else begin
        check_eq("wake_done", wake_done, 1);
        check_eq("wake_stall", core_stall, 0);
        check_eq("wake_src", wake_src, exp_src);
      end
    end
    last_src = exp_src;
    tick();
    check_eq("done_pulse", wake_done, 0);
    check_eq("src_after", wake_src, exp_src);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] m;
    logic [3:0] k;
    logic [3:0] p;
    bit         nat;
    bit         frc;
    int         ra;

    P_RSTn     = 1'b0;
    IDLE_req   = 1'b0;
    IDLE_mode  = 2'b00;
    IRQ_pend   = 4'b0;
    IRQ_msk    = 4'b0;
    PWDACK     = 1'b0;
    Awake      = 1'b0;
    force_wake = 1'b0;
    tmr_val    = '0;
    last_src   = 2'd0;

    #12;
    check_all_zero("reset");
    @(negedge DSPCLK);
    P_RSTn = 1'b1;
    tick();
    tick();

    // idle entry/exit, wake by IRQ 10 cycles later
    run_op(2'b00, 4'b0001, 4'b0000, 1, 0, 10, 0, 0, 0);
    // rejections: pending enabled IRQ, then reserved mode
    run_op(2'b00, 4'b0010, 4'b0010, 1, 0, 2, 0, 0, 0);
    run_op(2'b11, 4'b0000, 4'b0000, 1, 0, 2, 0, 0, 0);
    // sleep: PWDACK after a wait, Awake rise much later
    run_op(2'b10, 4'b0101, 4'b0000, 1, 0, 34, 4, 0, 0);
    // standby: force and IRQ coincide
    run_op(2'b01, 4'b0110, 4'b0000, 1, 1, 3, 0, 0, 0);
    // IRQ during ENTER
    run_op(2'b01, 4'b1011, 4'b0000, 1, 0, 0, 0, 0, 0);
    // reset mid-settle
    run_op(2'b00, 4'b1000, 4'b0000, 1, 0, 2, 0, 2, 0);
    // sleep woken by force while waiting for PWDACK
    run_op(2'b10, 4'b0000, 4'b0000, 0, 1, 0, 3, 0, 0);
`ifdef PWR_WAKE_TMR_EN
    run_op(2'b00, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 8);
    run_op(2'b00, 4'b0001, 4'b0000, 1, 0, 20, 0, 0, 0);
`endif

    for (int n = 0; n < 60; n++) begin
      m   = 2'($urandom);
      k   = 4'($urandom);
      p   = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
      nat = 1'($urandom);
      frc = 1'($urandom);
      if (m != 2'b10 && k == 4'b0) nat = 1'b0;
      if (!nat) frc = 1'b1;
      ra  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, SETTLE - 1) : 0;
      run_op(m, k, p, nat, frc, $urandom_range(0, 6), $urandom_range(0, 5), ra, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
